// File: rtl/coherence_bus_arbiter.sv
// rtl/coherence_bus_arbiter.sv - round-robin snooping-bus arbiter between MSI cache controllers and memory

module coherence_bus_arbiter #(
  parameter int N_CACHES = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2*N_CACHES-1:0] req_cmd,
  output logic [N_CACHES-1:0]   grant,
  output logic [N_CACHES-1:0]   done,
  output logic                  error,
  output logic [1:0]            snoop_cmd,
  output logic [N_CACHES-1:0]   snoop_en,
  input  logic [N_CACHES-1:0]   snoop_write_back,
  input  logic [N_CACHES-1:0]   snoop_abort,
  output logic                  mem_req,
  output logic                  mem_write,
  input  logic                  mem_ack,
  output logic [2:0]            owner_id,
  output logic [2:0]            state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SNOOP = 3'd1;
  localparam logic [2:0] S_RESP  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CMD_INV = 2'b11;

  logic [2:0]          state_next;
  logic [2:0]          rr_ptr;
  logic [1:0]          cmd_q;
  logic                ab_flag;
  logic                err_flag;
  logic [CNT_W-1:0]    wait_cnt;

  logic                pick_found;
  logic [2:0]          pick_id;
  logic [1:0]          pick_cmd;
  logic [3:0]          scan_idx;

  logic [N_CACHES-1:0] owner_onehot;
  logic                wb_any;
  logic                ab_any;
  logic                timeout_hit;

  assign owner_onehot = {{(N_CACHES-1){1'b0}}, 1'b1} << owner_id;

  // The owner's own snoop lines are meaningless, so they never count as hits.
  assign wb_any = |(snoop_write_back & ~owner_onehot);
  assign ab_any = |(snoop_abort & ~owner_onehot);

  // A mem_ack arriving in the final wait cycle still wins over the timeout.
  assign timeout_hit = !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Round-robin scan starting just after the last owner; first active node wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_cmd   = '0;
    scan_idx   = '0;
    for (int k = 1; k <= N_CACHES; k++) begin
      scan_idx = 4'((32'(rr_ptr) + k) % N_CACHES);
      if (!pick_found && req_cmd[2*scan_idx +: 2] != 2'b00) begin
        pick_found = 1'b1;
        pick_id    = scan_idx[2:0];
        pick_cmd   = req_cmd[2*scan_idx +: 2];
      end
    end
  end

  // State register; reset returns to IDLE so every derived output drops at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision for one bus transaction.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_next = S_SNOOP;
        end
      end
      S_SNOOP: begin
        state_next = S_RESP;
      end
      S_RESP: begin
        if (wb_any) begin
          state_next = S_WB;
        end else if (cmd_q == CMD_INV) begin
          state_next = S_DONE;
        end else begin
          state_next = S_MEM;
        end
      end
      S_WB: begin
        if (mem_ack) begin
          // An aborting snooper supplies the line, and an invalidate needs no fill.
          if (ab_flag || cmd_q == CMD_INV) begin
            state_next = S_DONE;
          end else begin
            state_next = S_MEM;
          end
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_MEM: begin
        if (mem_ack || timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Transaction context: owner, command, snoop abort, timeout flag, rotation pointer, wait counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_id <= '0;
      cmd_q    <= '0;
      rr_ptr   <= 3'(N_CACHES - 1);
      ab_flag  <= 1'b0;
      err_flag <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (state == S_IDLE && pick_found) begin
        owner_id <= pick_id;
        cmd_q    <= pick_cmd;
        ab_flag  <= 1'b0;
        err_flag <= 1'b0;
      end
      if (state == S_RESP) begin
        ab_flag <= ab_any;
      end
      if ((state == S_WB || state == S_MEM) && timeout_hit) begin
        err_flag <= 1'b1;
      end
      if (state == S_DONE) begin
        rr_ptr <= owner_id;
      end
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (mem_req) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Bus, snoop and memory outputs decoded from the current state.
  always_comb begin
    grant     = '0;
    done      = '0;
    error     = 1'b0;
    snoop_cmd = 2'b00;
    snoop_en  = '0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    case (state)
      S_SNOOP: begin
        grant     = owner_onehot;
        snoop_cmd = cmd_q;
        snoop_en  = ~owner_onehot;
      end
      S_RESP: begin
        grant = owner_onehot;
      end
      S_WB: begin
        grant     = owner_onehot;
        mem_req   = 1'b1;
        mem_write = 1'b1;
      end
      S_MEM: begin
        grant   = owner_onehot;
        mem_req = 1'b1;
      end
      S_DONE: begin
        grant = owner_onehot;
        done  = owner_onehot;
        error = err_flag;
      end
      default: begin
        grant = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// tb/tb_coherence_bus_arbiter.sv - directed self-checking bench for coherence_bus_arbiter

module tb_coherence_bus_arbiter;

  logic       clock;
  logic       reset;
  logic [7:0] req_cmd;
  logic [3:0] grant;
  logic [3:0] done;
  logic       error;
  logic [1:0] snoop_cmd;
  logic [3:0] snoop_en;
  logic [3:0] snoop_write_back;
  logic [3:0] snoop_abort;
  logic       mem_req;
  logic       mem_write;
  logic       mem_ack;
  logic [2:0] owner_id;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  int cnt;
  int exp_own [5] = '{0, 1, 2, 3, 0};

  coherence_bus_arbiter #(.N_CACHES(4), .TIMEOUT(15)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_cmd          (req_cmd),
    .grant            (grant),
    .done             (done),
    .error            (error),
    .snoop_cmd        (snoop_cmd),
    .snoop_en         (snoop_en),
    .snoop_write_back (snoop_write_back),
    .snoop_abort      (snoop_abort),
    .mem_req          (mem_req),
    .mem_write        (mem_write),
    .mem_ack          (mem_ack),
    .owner_id         (owner_id),
    .state            (state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset            = 1'b1;
    req_cmd          = 8'h00;
    snoop_write_back = 4'h0;
    snoop_abort      = 4'h0;
    mem_ack          = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_snoop_en", 32'(snoop_en), 32'h0);
    chk("rst_owner", 32'(owner_id), 32'd0);
    reset = 1'b0;
    tick();

    // 1: node 2 read miss, owner's own write_back masked, mem_ack one cycle late
    req_cmd = 8'h10;
    tick();
    chk("t1_state_snoop", 32'(state), 32'd1);
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_snoop_en", 32'(snoop_en), 32'hb);
    chk("t1_snoop_cmd", 32'(snoop_cmd), 32'd1);
    chk("t1_owner", 32'(owner_id), 32'd2);
    snoop_write_back = 4'h4;
    tick();
    chk("t1_state_resp", 32'(state), 32'd2);
    chk("t1_snoop_en_off", 32'(snoop_en), 32'h0);
    chk("t1_snoop_cmd_off", 32'(snoop_cmd), 32'd0);
    tick();
    snoop_write_back = 4'h0;
    chk("t1_state_mem", 32'(state), 32'd4);
    chk("t1_memreq", 32'(mem_req), 32'd1);
    chk("t1_memwrite", 32'(mem_write), 32'd0);
    tick();
    chk("t1_memreq_held", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t1_done", 32'(done), 32'h4);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_memreq_off", 32'(mem_req), 32'd0);
    req_cmd = 8'h00;
    tick();
    chk("t1_idle", 32'(state), 32'd0);
    chk("t1_grant_off", 32'(grant), 32'h0);
    chk("t1_done_off", 32'(done), 32'h0);

    // 2: node 0 write miss, node 3 writes back and aborts
    req_cmd = 8'h02;
    tick();
    chk("t2_grant", 32'(grant), 32'h1);
    chk("t2_snoop_en", 32'(snoop_en), 32'he);
    chk("t2_snoop_cmd", 32'(snoop_cmd), 32'd2);
    snoop_write_back = 4'h8;
    snoop_abort      = 4'h8;
    tick();
    chk("t2_state_resp", 32'(state), 32'd2);
    tick();
    snoop_write_back = 4'h0;
    snoop_abort      = 4'h0;
    chk("t2_state_wb", 32'(state), 32'd3);
    chk("t2_memreq", 32'(mem_req), 32'd1);
    chk("t2_memwrite", 32'(mem_write), 32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2_state_done", 32'(state), 32'd5);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_memreq_off", 32'(mem_req), 32'd0);
    req_cmd = 8'h00;
    tick();
    chk("t2_idle", 32'(state), 32'd0);

    // 3: node 1 invalidate, no memory access
    req_cmd = 8'h0c;
    tick();
    chk("t3_grant", 32'(grant), 32'h2);
    chk("t3_snoop_cmd", 32'(snoop_cmd), 32'd3);
    chk("t3_snoop_en", 32'(snoop_en), 32'hd);
    tick();
    chk("t3_memreq_resp", 32'(mem_req), 32'd0);
    tick();
    chk("t3_state_done", 32'(state), 32'd5);
    chk("t3_done", 32'(done), 32'h2);
    chk("t3_memreq_done", 32'(mem_req), 32'd0);
    req_cmd = 8'h00;
    tick();

    // 4: all nodes invalidate together after a fresh reset; node 0 keeps requesting
    reset = 1'b1;
    tick();
    chk("t4_rst_state", 32'(state), 32'd0);
    reset   = 1'b0;
    req_cmd = 8'hff;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_grant_%0d", i), 32'(grant), 32'h1 << exp_own[i]);
      tick();
      tick();
      chk($sformatf("t4_done_%0d", i), 32'(done), 32'h1 << exp_own[i]);
      if (exp_own[i] != 0 || i == 4) begin
        req_cmd[2*exp_own[i] +: 2] = 2'b00;
      end
      tick();
    end
    chk("t4_all_dropped", 32'(req_cmd), 32'h0);

    // 5: node 2 read, mem_ack withheld until timeout
    req_cmd = 8'h10;
    tick();
    chk("t5_grant", 32'(grant), 32'h4);
    tick();
    tick();
    chk("t5_state_mem", 32'(state), 32'd4);
    cnt = 0;
    while (mem_req && cnt < 30) begin
      cnt++;
      tick();
    end
    chk("t5_memreq_cycles", 32'(cnt), 32'd15);
    chk("t5_state_done", 32'(state), 32'd5);
    chk("t5_done", 32'(done), 32'h4);
    chk("t5_error", 32'(error), 32'd1);
    req_cmd = 8'h00;
    tick();
    chk("t5_error_off", 32'(error), 32'd0);
    chk("t5_idle", 32'(state), 32'd0);
    req_cmd = 8'h04;
    tick();
    chk("t5b_grant", 32'(grant), 32'h2);
    tick();
    tick();
    chk("t5b_state_mem", 32'(state), 32'd4);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t5b_done", 32'(done), 32'h2);
    chk("t5b_error", 32'(error), 32'd0);
    req_cmd = 8'h00;
    tick();

    // 6: reset during MEM, then node 0 has priority
    req_cmd = 8'h40;
    tick();
    chk("t6_grant", 32'(grant), 32'h8);
    tick();
    tick();
    chk("t6_memreq", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_grant", 32'(grant), 32'h0);
    chk("t6_async_memreq", 32'(mem_req), 32'd0);
    chk("t6_async_snoop_en", 32'(snoop_en), 32'h0);
    chk("t6_async_state", 32'(state), 32'd0);
    chk("t6_async_owner", 32'(owner_id), 32'd0);
    chk("t6_async_done", 32'(done), 32'h0);
    #1;
    reset   = 1'b0;
    req_cmd = 8'h41;
    tick();
    chk("t6_prio_grant", 32'(grant), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
